cache_port_arbiter: RTL and testbench

//  Shares the single CPU-side port of the 4-way cache (cache) between the instruction

---
 rtl/cache_port_arbiter_pkg.sv | 24 ++
 rtl/cache_port_arbiter_if.sv | 54 +++++
 rtl/cache_port_arbiter_rr_arb2.sv | 38 +++
 rtl/cache_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_cache_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and bus widths for the cache CPU-port arbiter.
package cache_port_arbiter_pkg;

  localparam int CACHE_ADDR_W = 25;
  localparam int CACHE_DATA_W = 32;
  localparam int CACHE_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Transaction counters wrap silently at 2^32.
  function automatic logic [31:0] cnt_inc(input logic [31:0] c);
    return c + 32'd1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signals of the arbiter, bundled.
// master: fetch/load-store requesters and cache; slave: the arbiter.
interface cache_port_arbiter_if
  import cache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int BE_W   = CACHE_BE_W
) ();

  logic [ADDR_W-1:0] if_addr_i;
  logic              if_read_i;
  logic              if_cancel_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_rvalid_o;
  logic              if_wait_o;

  logic [ADDR_W-1:0] mem_addr_i;
  logic [BE_W-1:0]   mem_be_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_rvalid_o;
  logic              mem_wait_o;

  logic [ADDR_W-1:0] o_p_addr;
  logic [BE_W-1:0]   o_p_byte_en;
  logic [DATA_W-1:0] o_p_writedata;
  logic              o_p_read;
  logic              o_p_write;
  logic [DATA_W-1:0] i_p_readdata;
  logic              i_p_readdata_valid;
  logic              i_p_waitrequest;

  modport master (
    output if_addr_i, if_read_i, if_cancel_i,
    input  if_rdata_o, if_rvalid_o, if_wait_o,
    output mem_addr_i, mem_be_i, mem_wdata_i, mem_read_i, mem_write_i,
    input  mem_rdata_o, mem_rvalid_o, mem_wait_o,
    input  o_p_addr, o_p_byte_en, o_p_writedata, o_p_read, o_p_write,
    output i_p_readdata, i_p_readdata_valid, i_p_waitrequest
  );

  modport slave (
    input  if_addr_i, if_read_i, if_cancel_i,
    output if_rdata_o, if_rvalid_o, if_wait_o,
    input  mem_addr_i, mem_be_i, mem_wdata_i, mem_read_i, mem_write_i,
    output mem_rdata_o, mem_rvalid_o, mem_wait_o,
    output o_p_addr, o_p_byte_en, o_p_writedata, o_p_read, o_p_write,
    input  i_p_readdata, i_p_readdata_valid, i_p_waitrequest
  );

endinterface

// File: rtl/cache_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker: combinational grant, registered last winner.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
  import cache_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_if,
  input  logic   req_mem,
  input  logic   advance,
  output logic   gnt_vld,
  output owner_e gnt
);

  owner_e last_gnt;

  assign gnt_vld = req_if | req_mem;

  // Pick the winner for this cycle from the requests and the previous winner.
  always_comb begin
    gnt = OWN_IF;
    if (req_if && req_mem) begin
      gnt = (last_gnt == OWN_IF) ? OWN_MEM : OWN_IF;
    end else if (req_mem) begin
      gnt = OWN_MEM;
    end
  end

  // Remember the winner whenever a grant is actually taken; MEM at reset so IF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWN_MEM;
    end else if (advance && gnt_vld) begin
      last_gnt <= gnt;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the single cache CPU port between instruction fetch and load/store.
// One transaction outstanding at a time; results routed back to the owner.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  parameter int BE_W   = CACHE_BE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_port_arbiter_if.slave bus,
  output logic [31:0]         cnt_if_o,
  output logic [31:0]         cnt_mem_o
);

  state_e            state;
  owner_e            owner;
  logic              drop;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_rd;
  logic              cmd_wr;

  logic   req_if;
  logic   req_mem;
  logic   gnt_vld;
  owner_e gnt;
  logic   cmd_accept;
  logic   read_done;
  logic   done;
  logic   done_if;
  logic   done_mem;
  logic   if_rvalid;
  logic   mem_rvalid;

  // A cancelled fetch must not be granted; load/store may still win that cycle.
  assign req_if  = bus.if_read_i & ~bus.if_cancel_i;
  assign req_mem = bus.mem_read_i | bus.mem_write_i;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (req_if),
    .req_mem (req_mem),
    .advance (state == IDLE),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  // Completion decode: writes finish on accept, reads when data returns.
  assign cmd_accept = (state == ISSUE) & ~bus.i_p_waitrequest;
  assign read_done  = (cmd_accept & cmd_rd & bus.i_p_readdata_valid) |
                      ((state == WAIT_RD) & bus.i_p_readdata_valid);
  assign done       = (cmd_accept & cmd_wr) | read_done;
  assign done_if    = done & (owner == OWN_IF);
  assign done_mem   = done & (owner == OWN_MEM);

  // A squashed fetch still completes at the cache but its data is not delivered.
  assign if_rvalid  = read_done & (owner == OWN_IF) & ~drop & ~bus.if_cancel_i;
  assign mem_rvalid = read_done & (owner == OWN_MEM);

  assign bus.if_wait_o    = ~done_if;
  assign bus.if_rvalid_o  = if_rvalid;
  assign bus.if_rdata_o   = if_rvalid ? bus.i_p_readdata : '0;
  assign bus.mem_wait_o   = ~done_mem;
  assign bus.mem_rvalid_o = mem_rvalid;
  assign bus.mem_rdata_o  = mem_rvalid ? bus.i_p_readdata : '0;

  assign bus.o_p_addr      = cmd_addr;
  assign bus.o_p_byte_en   = cmd_be;
  assign bus.o_p_writedata = cmd_wdata;
  assign bus.o_p_read      = cmd_rd;
  assign bus.o_p_write     = cmd_wr;

  // Transaction FSM: grant in IDLE, present command in ISSUE, wait for read data in WAIT_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      drop      <= 1'b0;
      cmd_addr  <= '0;
      cmd_be    <= '0;
      cmd_wdata <= '0;
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      cnt_if_o  <= '0;
      cnt_mem_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (gnt_vld) begin
            owner <= gnt;
            state <= ISSUE;
            if (gnt == OWN_IF) begin
              // Fetch always reads a full word.
              cmd_addr  <= bus.if_addr_i;
              cmd_be    <= '1;
              cmd_wdata <= '0;
              cmd_rd    <= 1'b1;
              cmd_wr    <= 1'b0;
            end else begin
              cmd_addr  <= bus.mem_addr_i;
              cmd_be    <= bus.mem_be_i;
              cmd_wdata <= bus.mem_wdata_i;
              cmd_rd    <= bus.mem_read_i;
              cmd_wr    <= bus.mem_write_i;
            end
          end
        end
        ISSUE: begin
          if (bus.if_cancel_i && (owner == OWN_IF)) begin
            drop <= 1'b1;
          end
          if (cmd_accept) begin
            cmd_rd <= 1'b0;
            cmd_wr <= 1'b0;
            state  <= done ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.if_cancel_i && (owner == OWN_IF)) begin
            drop <= 1'b1;
          end
          if (bus.i_p_readdata_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (done_if) begin
        cnt_if_o <= cnt_inc(cnt_if_o);
      end
      if (done_mem) begin
        cnt_mem_o <= cnt_inc(cnt_mem_o);
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: transaction-level reference model checked every
// cycle, a simple cache responder, and directed scenarios with literal expectations.
module tb_cache_port_arbiter;
  import cache_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cnt_if_o;
  logic [31:0] cnt_mem_o;

  cache_port_arbiter_if bus ();

  cache_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cnt_if_o  (cnt_if_o),
    .cnt_mem_o (cnt_mem_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Responder configuration and requester release flags.
  int  rsp_wait = 0;
  int  rsp_lat  = 0;
  bit  stray    = 1'b0;
  bit  if_rel   = 1'b0;
  bit  mem_rel  = 1'b0;

  // Observations of DUT completions for literal checks.
  int          comp_log[$];
  int          n_if_rv  = 0;
  int          n_mem_rv = 0;
  logic [31:0] last_if_rdata  = '0;
  logic [31:0] last_mem_rdata = '0;

  // Reference model state: one outstanding transaction described abstractly.
  bit          m_busy, m_acc, m_wr, m_drop;
  int          m_own;
  int          m_last;
  logic [24:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt_if, m_cnt_mem;

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_wr = 0; m_drop = 0; m_own = 0; m_last = 1;
    m_addr = '0; m_be = '0; m_wdata = '0; m_cnt_if = '0; m_cnt_mem = '0;
  endtask

  // Compare process: evaluate the model against the DUT on every falling edge.
  initial begin
    bit e_cmd, e_rd, e_wr, cmp, e_if_done, e_mem_done, e_if_rv, e_mem_rv, r_if, r_mem;
    int own;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_o_p_read", bus.o_p_read, 0);
        chk("rst_o_p_write", bus.o_p_write, 0);
        chk("rst_o_p_addr", bus.o_p_addr, 0);
        chk("rst_if_wait", bus.if_wait_o, 1);
        chk("rst_mem_wait", bus.mem_wait_o, 1);
        chk("rst_if_rvalid", bus.if_rvalid_o, 0);
        chk("rst_mem_rvalid", bus.mem_rvalid_o, 0);
        chk("rst_cnt_if", cnt_if_o, 0);
        chk("rst_cnt_mem", cnt_mem_o, 0);
      end else begin
        e_cmd = m_busy && !m_acc;
        e_rd  = e_cmd && !m_wr;
        e_wr  = e_cmd && m_wr;
        cmp   = m_busy && ((e_cmd && !bus.i_p_waitrequest && (m_wr || bus.i_p_readdata_valid)) ||
                           (m_acc && bus.i_p_readdata_valid));
        e_if_done  = cmp && (m_own == 0);
        e_mem_done = cmp && (m_own == 1);
        e_if_rv    = e_if_done && !m_drop && !bus.if_cancel_i;
        e_mem_rv   = e_mem_done && !m_wr;

        chk("o_p_read", bus.o_p_read, e_rd);
        chk("o_p_write", bus.o_p_write, e_wr);
        chk("rd_wr_excl", bus.o_p_read & bus.o_p_write, 0);
        if (e_cmd) chk("o_p_addr", bus.o_p_addr, m_addr);
        if (e_wr) begin
          chk("o_p_byte_en", bus.o_p_byte_en, m_be);
          chk("o_p_writedata", bus.o_p_writedata, m_wdata);
        end
        chk("if_wait", bus.if_wait_o, !e_if_done);
        chk("mem_wait", bus.mem_wait_o, !e_mem_done);
        chk("if_rvalid", bus.if_rvalid_o, e_if_rv);
        chk("mem_rvalid", bus.mem_rvalid_o, e_mem_rv);
        chk("if_rdata", bus.if_rdata_o, e_if_rv ? bus.i_p_readdata : 32'h0);
        chk("mem_rdata", bus.mem_rdata_o, e_mem_rv ? bus.i_p_readdata : 32'h0);
        chk("cnt_if", cnt_if_o, m_cnt_if);
        chk("cnt_mem", cnt_mem_o, m_cnt_mem);

        if (!bus.if_wait_o)  begin comp_log.push_back(0); if_rel = 1; end
        if (!bus.mem_wait_o) begin comp_log.push_back(1); mem_rel = 1; end
        if (bus.if_rvalid_o)  begin n_if_rv++;  last_if_rdata  = bus.if_rdata_o;  end
        if (bus.mem_rvalid_o) begin n_mem_rv++; last_mem_rdata = bus.mem_rdata_o; end

        if (!m_busy) begin
          r_if  = bus.if_read_i && !bus.if_cancel_i;
          r_mem = bus.mem_read_i || bus.mem_write_i;
          if (r_if || r_mem) begin
            own = (r_if && r_mem) ? (1 - m_last) : (r_mem ? 1 : 0);
            m_last = own; m_own = own; m_busy = 1; m_acc = 0; m_drop = 0;
            if (own == 0) begin
              m_addr = bus.if_addr_i; m_wr = 0;
            end else begin
              m_addr = bus.mem_addr_i; m_wr = bus.mem_write_i;
              m_be = bus.mem_be_i; m_wdata = bus.mem_wdata_i;
            end
          end
        end else begin
          if (m_own == 0 && bus.if_cancel_i) m_drop = 1;
          if (e_cmd && !bus.i_p_waitrequest) m_acc = 1;
          if (cmp) begin
            m_busy = 0;
            if (m_own == 0) m_cnt_if = m_cnt_if + 1;
            else            m_cnt_mem = m_cnt_mem + 1;
          end
        end
      end
    end
  end

  // Cache responder: waitrequest for rsp_wait cycles, read data rsp_lat cycles after accept.
  initial begin
    bit          r_cmd = 0;
    bit          r_isrd = 0;
    int          r_wleft = 0;
    int          r_lat = 0;
    logic [31:0] r_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_p_readdata_valid = 1'b0;
      bus.i_p_readdata       = '0;
      bus.i_p_waitrequest    = 1'b0;
      if (!rst_n) begin
        r_cmd = 0; r_lat = 0;
      end else begin
        if (stray) begin
          bus.i_p_readdata_valid = 1'b1; bus.i_p_readdata = 32'hBAD0_BAD0; stray = 0;
        end
        if (r_lat > 0) begin
          r_lat--;
          if (r_lat == 0) begin bus.i_p_readdata_valid = 1'b1; bus.i_p_readdata = r_data; end
        end
        if ((bus.o_p_read || bus.o_p_write) && !r_cmd) begin
          r_cmd = 1; r_wleft = rsp_wait; r_isrd = bus.o_p_read;
          r_data = {7'h0, bus.o_p_addr} ^ 32'hC0DE_0000;
        end
        if (r_cmd) begin
          if (r_wleft > 0) begin
            bus.i_p_waitrequest = 1'b1; r_wleft--;
          end else begin
            r_cmd = 0;
            if (r_isrd) begin
              if (rsp_lat == 0) begin bus.i_p_readdata_valid = 1'b1; bus.i_p_readdata = r_data; end
              else r_lat = rsp_lat;
            end
          end
        end
      end
    end
  end

  // Advance one cycle; requesters drop their request the cycle after completion.
  task automatic tick();
    @(posedge clk); #1;
    if (if_rel)  begin bus.if_read_i = 1'b0; if_rel = 0; end
    if (mem_rel) begin bus.mem_read_i = 1'b0; bus.mem_write_i = 1'b0; mem_rel = 0; end
  endtask

  task automatic drain(input int max_cyc);
    bit pending;
    pending = 1;
    for (int i = 0; i < max_cyc && pending; i++) begin
      tick();
      pending = bus.if_read_i || bus.mem_read_i || bus.mem_write_i;
    end
    chk("drain_timeout", pending, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.if_read_i = 0; bus.mem_read_i = 0; bus.mem_write_i = 0; bus.if_cancel_i = 0;
    if_rel = 0; mem_rel = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rv0;
    bus.if_addr_i = '0; bus.if_read_i = 0; bus.if_cancel_i = 0;
    bus.mem_addr_i = '0; bus.mem_be_i = '0; bus.mem_wdata_i = '0;
    bus.mem_read_i = 0; bus.mem_write_i = 0;
    bus.i_p_readdata = '0; bus.i_p_readdata_valid = 0; bus.i_p_waitrequest = 0;
    rst_n = 1'b0;
    tick(); tick();
    chk("lit_rst_if_wait", bus.if_wait_o, 1);
    chk("lit_rst_cnt_if", cnt_if_o, 0);
    rst_n = 1'b1;

    // IF read hit: one-cycle command, rvalid pulse with data.
    rsp_wait = 0; rsp_lat = 0;
    tick();
    bus.if_addr_i = 25'h10; bus.if_read_i = 1;
    #2;
    chk("t1_req_o_p_read", bus.o_p_read, 0);
    tick(); #2;
    chk("t1_o_p_read", bus.o_p_read, 1);
    chk("t1_o_p_addr", bus.o_p_addr, 25'h10);
    chk("t1_if_rvalid", bus.if_rvalid_o, 1);
    chk("t1_if_rdata", bus.if_rdata_o, 32'hC0DE_0010);
    chk("t1_if_wait", bus.if_wait_o, 0);
    chk("t1_mem_wait", bus.mem_wait_o, 1);
    tick(); #2;
    chk("t1_o_p_read_off", bus.o_p_read, 0);
    chk("t1_cnt_if", cnt_if_o, 1);

    // Ties after reset: IF, MEM, then IF, MEM again.
    do_reset();
    comp_log.delete();
    rsp_lat = 1;
    bus.if_addr_i = 25'h20; bus.if_read_i = 1;
    bus.mem_addr_i = 25'h1_0040; bus.mem_read_i = 1;
    drain(40);
    bus.if_read_i = 1; bus.mem_read_i = 1;
    drain(40);
    chk("t2_log_size", comp_log.size(), 4);
    if (comp_log.size() == 4) begin
      chk("t2_grant0", comp_log[0], 0);
      chk("t2_grant1", comp_log[1], 1);
      chk("t2_grant2", comp_log[2], 0);
      chk("t2_grant3", comp_log[3], 1);
    end
    chk("t2_cnt_if", cnt_if_o, 2);
    chk("t2_cnt_mem", cnt_mem_o, 2);

    // Store with three cycles of waitrequest.
    rsp_wait = 3; rsp_lat = 0;
    rv0 = n_mem_rv;
    bus.mem_addr_i = 25'h0ABCD; bus.mem_be_i = 4'b0011; bus.mem_wdata_i = 32'hDEAD_BEEF;
    bus.mem_write_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); #2;
      chk("t3_hold_write", bus.o_p_write, 1);
      chk("t3_hold_be", bus.o_p_byte_en, 4'b0011);
      chk("t3_hold_wdata", bus.o_p_writedata, 32'hDEAD_BEEF);
      chk("t3_hold_wait", bus.mem_wait_o, 1);
    end
    tick(); #2;
    chk("t3_accept_wait", bus.mem_wait_o, 0);
    chk("t3_accept_write", bus.o_p_write, 1);
    chk("t3_accept_rvalid", bus.mem_rvalid_o, 0);
    tick(); #2;
    chk("t3_write_off", bus.o_p_write, 0);
    chk("t3_cnt_mem", cnt_mem_o, 3);
    chk("t3_no_rvalid", n_mem_rv, rv0);

    // Fetch miss cancelled while waiting for data.
    rsp_wait = 0; rsp_lat = 8;
    rv0 = n_if_rv;
    bus.if_addr_i = 25'h0300; bus.if_read_i = 1;
    tick(); tick(); tick();
    bus.if_cancel_i = 1;
    #2;
    chk("t4_wait_rd_read", bus.o_p_read, 0);
    tick();
    bus.if_cancel_i = 0;
    drain(30);
    chk("t4_no_rvalid", n_if_rv, rv0);
    chk("t4_cnt_if", cnt_if_o, 3);
    chk("t4_last_done_if", comp_log[comp_log.size()-1], 0);
    rsp_lat = 0;
    bus.if_addr_i = 25'h0304; bus.if_read_i = 1;
    drain(20);
    chk("t4_next_rvalid", n_if_rv, rv0 + 1);
    chk("t4_next_rdata", last_if_rdata, 32'hC0DE_0304);
    chk("t4_next_cnt_if", cnt_if_o, 4);

    // Reset during WAIT_RD, stray valid afterwards, then a clean load.
    rsp_lat = 5;
    bus.mem_addr_i = 25'h1F00; bus.mem_read_i = 1;
    tick(); tick(); tick(); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_read", bus.o_p_read, 0);
    chk("t5_rst_addr", bus.o_p_addr, 0);
    chk("t5_rst_mem_wait", bus.mem_wait_o, 1);
    chk("t5_rst_cnt_if", cnt_if_o, 0);
    chk("t5_rst_cnt_mem", cnt_mem_o, 0);
    bus.mem_read_i = 0; mem_rel = 0; if_rel = 0;
    tick(); tick();
    rst_n = 1'b1;
    stray = 1;
    rv0 = n_mem_rv;
    tick(); tick(); tick();
    chk("t5_stray_rvalid", n_mem_rv, rv0);
    chk("t5_stray_cnt", cnt_mem_o, 0);
    rsp_lat = 2;
    bus.mem_addr_i = 25'h1F04; bus.mem_read_i = 1;
    drain(20);
    chk("t5_cnt_mem", cnt_mem_o, 1);
    chk("t5_rvalid", n_mem_rv, rv0 + 1);
    chk("t5_rdata", last_mem_rdata, 32'hC0DE_1F04);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
